ir_tx_scheduler: RTL

IR_TX_SCHEDULER -- requirements
Module: ir_tx_scheduler

---
 rtl/ir_tx_scheduler.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/ir_tx_scheduler.sv
// ir_tx_scheduler: bus-programmed periodic / one-shot trigger for an IR
// transmitter, with request coalescing, overrun count and holdoff guard.
module ir_tx_scheduler #(
  parameter logic [7:0]  BASE_ADDR      = 8'h90,
  parameter int unsigned PERIOD_CYCLES  = 10_000_000,
  parameter int unsigned HOLDOFF_CYCLES = 2_000_000
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic [7:0] BUS_ADDR,
  input  logic [7:0] BUS_DATA_IN,
  input  logic       BUS_WE,
  output logic [7:0] BUS_DATA_OUT,
  output logic       BUS_DATA_OUT_WE,
  output logic [3:0] COMMAND,
  output logic       SEND_PACKET
);
  localparam int PW = $clog2(PERIOD_CYCLES);
  localparam int HW = $clog2(HOLDOFF_CYCLES);
  localparam logic [PW-1:0] P_LAST = PW'(PERIOD_CYCLES - 1);
  localparam logic [HW-1:0] H_LAST = HW'(HOLDOFF_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ARM, FIRE, HOLD} state_e;
  state_e state_q, state_d;

  logic [3:0]    cmd_q, cmd_d;
  logic          en_q, en_d;
  logic          pend_q, pend_d;
  logic [7:0]    ovr_q, ovr_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [3:0]    command_q, command_d;
  logic          send_q, send_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          rdwe_q, rdwe_d;

  logic [7:0] off;
  logic [7:0] rmux;
  logic in_win, wr_cmd, wr_ctrl, wr_ovr, rd_en;
  logic oneshot, en_rise, tick, req;
  logic arm_entry, hold_done, busy;
  logic unused_din;

  assign unused_din = ^BUS_DATA_IN[7:4];

  always_comb begin
    off     = BUS_ADDR - BASE_ADDR;
    in_win  = (off[7:2] == 6'd0);
    wr_cmd  = BUS_WE && in_win && (off[1:0] == 2'd0);
    wr_ctrl = BUS_WE && in_win && (off[1:0] == 2'd1);
    wr_ovr  = BUS_WE && in_win && (off[1:0] == 2'd3);
    rd_en   = !BUS_WE && in_win;
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (pend_q) state_d = ARM;
      ARM:  state_d = FIRE;
      FIRE: state_d = HOLD;
      HOLD: if (hold_done) state_d = pend_q ? ARM : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    arm_entry = (state_d == ARM);
    send_d    = (state_d == FIRE);
    command_d = arm_entry ? cmd_q : command_q;
  end

  always_comb begin
    cmd_d     = wr_cmd ? BUS_DATA_IN[3:0] : cmd_q;
    en_d      = wr_ctrl ? BUS_DATA_IN[0] : en_q;
    en_rise   = wr_ctrl && BUS_DATA_IN[0] && !en_q;
    oneshot   = wr_ctrl && BUS_DATA_IN[1];
    tick      = en_q && (pcnt_q == P_LAST);
    req       = tick || oneshot;
    pcnt_d    = (!en_d || en_rise || tick) ? '0 : pcnt_q + PW'(1);
    hold_done = (state_q == HOLD) && (hcnt_q == H_LAST);
    hcnt_d    = (state_q == HOLD && !hold_done) ? hcnt_q + HW'(1) : '0;
    // a request landing on the ARM edge is the one that stays pending
    pend_d    = req || (pend_q && !arm_entry);
    ovr_d     = ovr_q;
    if (wr_ovr)
      ovr_d = 8'h00;
    else if (req && pend_q && !arm_entry && ovr_q != 8'hFF)
      ovr_d = ovr_q + 8'd1;
  end

  always_comb begin
    rmux = 8'h00;
    unique case (off[1:0])
      2'd0: rmux = {4'b0, cmd_q};
      2'd1: rmux = {7'b0, en_q};
      2'd2: rmux = {5'b0, busy, pend_q, en_q};
      2'd3: rmux = ovr_q;
      default: rmux = 8'h00;
    endcase
    rdwe_d  = rd_en;
    rdata_d = rd_en ? rmux : 8'h00;
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      cmd_q     <= '0;
      en_q      <= 1'b0;
      pend_q    <= 1'b0;
      ovr_q     <= '0;
      pcnt_q    <= '0;
      hcnt_q    <= '0;
      command_q <= '0;
      send_q    <= 1'b0;
      rdata_q   <= '0;
      rdwe_q    <= 1'b0;
    end else begin
      cmd_q     <= cmd_d;
      en_q      <= en_d;
      pend_q    <= pend_d;
      ovr_q     <= ovr_d;
      pcnt_q    <= pcnt_d;
      hcnt_q    <= hcnt_d;
      command_q <= command_d;
      send_q    <= send_d;
      rdata_q   <= rdata_d;
      rdwe_q    <= rdwe_d;
    end
  end

  assign COMMAND         = command_q;
  assign SEND_PACKET     = send_q;
  assign BUS_DATA_OUT    = rdata_q;
  assign BUS_DATA_OUT_WE = rdwe_q;

endmodule
